// File: rtl/conv_result_streamer.sv
// 2x2 conv-result capture, max-pool and 5-beat valid/ready byte streamer.
// Optional build macro CONV_STREAM_RELU_EN: ReLU on capture (signed inputs clamped at 0).
module conv_result_streamer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] r00,
  input  logic [DATA_W-1:0] r01,
  input  logic [DATA_W-1:0] r10,
  input  logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]        state;
  logic [2:0]        beat_idx;
  logic [2:0]        nxt_idx;
  logic [DATA_W-1:0] e0, e1, e2, e3;
  logic [DATA_W-1:0] max_reg;
  logic [DATA_W-1:0] max_01, max_23, max_all;
  logic [DATA_W-1:0] nxt_data;

  function automatic logic [DATA_W-1:0] cap_elem(input logic [DATA_W-1:0] x);
`ifdef CONV_STREAM_RELU_EN
    return x[DATA_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  always_comb begin
    max_01  = (e0 > e1) ? e0 : e1;
    max_23  = (e2 > e3) ? e2 : e3;
    max_all = (max_01 > max_23) ? max_01 : max_23;
  end

  assign nxt_idx = beat_idx + 3'd1;

  always_comb begin
    nxt_data = max_reg;
    case (nxt_idx)
      3'd1:    nxt_data = e1;
      3'd2:    nxt_data = e2;
      3'd3:    nxt_data = e3;
      default: nxt_data = max_reg;
    endcase
  end

  // The first SEND cycle only loads the output register with beat 0, so every
  // stream output is a flop and out_ready never reaches out_valid combinationally.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_idx  <= '0;
      e0        <= '0;
      e1        <= '0;
      e2        <= '0;
      e3        <= '0;
      max_reg   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            e0    <= cap_elem(r00);
            e1    <= cap_elem(r01);
            e2    <= cap_elem(r10);
            e3    <= cap_elem(r11);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          max_reg  <= max_all;
          beat_idx <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= e0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (beat_idx == 3'd4) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              beat_idx  <= '0;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= ST_IDLE;
            end else begin
              beat_idx <= nxt_idx;
              out_data <= nxt_data;
              out_last <= (nxt_idx == 3'd4);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Downstream stage of the 1x1-PE systolic convolution core.
- Captures the core's 2x2 output feature map (o00, o01, o10, o11) when the core signals completion.
- Computes the 2x2 max-pool value.
- Emits the four elements plus the pooled maximum as a 5-beat byte stream on a valid/ready handshake toward the write-back or host interface.

Parameters:
- DATA_W, 8, width of each feature-map element and of the output stream.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk_in, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset; clears all state immediately.
- in_valid, input, 1, conv core results are final; one-cycle or level strobe.
- in_ready, output, 1, streamer can accept a new 2x2 result.
- r00, input, DATA_W, conv result row 0 col 0 (from o00).
- r01, input, DATA_W, conv result row 0 col 1 (from o01).
- r10, input, DATA_W, conv result row 1 col 0 (from o10).
- r11, input, DATA_W, conv result row 1 col 1 (from o11).
- out_data, output, DATA_W, stream byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts the beat when out_valid is also high.
- out_last, output, 1, high on the 5th (max) beat only.
- busy, output, 1, high in CALC or SEND.
- frame_cnt, output, CNT_W, number of fully transmitted frames.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, frame_cnt=0.
  - State=IDLE, beat index=0, capture and max registers=0.
- FSM states: IDLE, CALC, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a rising edge with in_valid=1: load r00,r01,r10,r11 into e0..e3 in that order, then go to CALC.
- CALC (exactly 1 cycle):
  - in_ready=0, busy=1.
  - At the next edge: max_reg <= max(e0,e1,e2,e3) using an unsigned compare tree; beat index <= 0; go to SEND.
- SEND:
  - out_valid=1, busy=1, in_ready=0.
  - out_data = e0,e1,e2,e3,max_reg for beat index 0..4.
  - out_last=1 only when beat index=4.
  - A beat transfers on an edge where out_valid=1 and out_ready=1; the index then increments.
  - On transfer of beat 4: go to IDLE and increment frame_cnt, wrapping modulo 2^CNT_W (255 -> 0).
- Latency:
  - Capture at edge E0.
  - out_valid rises after edge E0+2, so first beat is presented 2 cycles after capture.
  - Minimum frame length with out_ready held at 1: 7 cycles from capture to the next in_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
  - No beat is skipped or duplicated.
- in_valid outside IDLE is ignored.
  - The captured frame is not overwritten.
  - No error is flagged; the upstream core holds its outputs until restarted.
- Simultaneous events:
  - In the cycle the last beat transfers, in_ready is still 0.
  - A new capture is possible only from the following cycle, in IDLE.
- out_data is driven 0 whenever out_valid=0.
- Reset mid-frame:
  - State returns to IDLE and out_valid drops immediately, asynchronously.
  - The partial frame is discarded; frame_cnt is cleared.
- Outputs are registered or decoded from registered state only; there is no combinational path from out_ready to out_valid.

Optional Feature:
- Macro: CONV_STREAM_RELU_EN.
- Defined:
  - Capture treats r* as signed two's complement.
  - Any element with MSB=1 is stored as 0 (ReLU); others are stored unchanged.
  - The max is computed over the post-ReLU values.
- Not defined:
  - Elements are captured unchanged and treated as unsigned.
  - The max is an unsigned compare over the raw values.
- Port list and timing are identical in both builds.

Test Plan:
- Basic frame: reset, then in_valid with r=5,200,17,9 and out_ready=1.
  - Beats are 5,200,17,9,200; out_last only on 200.
  - frame_cnt=1; in_ready returns 1 the cycle after the last beat.
- Backpressure: same frame, out_ready toggled 1,0,0,1,0,1...
  - Each beat is held stable while stalled.
  - Exactly 5 transfers, in order; out_last is held with the value 200.
- ReLU build (CONV_STREAM_RELU_EN): r=0xF0,0x03,0x80,0x7F.
  - Stream is 0,3,0,127,127.
  - Without the macro, the same stimulus gives 0xF0,0x03,0x80,0x7F,0xF0.
- Ignored input: pulse in_valid with r=1,1,1,1 during SEND of a 10,20,30,40 frame.
  - Stream is 10,20,30,40,40 unaffected.
  - Only one frame is counted.
- Reset mid-stream: assert rst after beat 2 has transferred.
  - out_valid=0 and frame_cnt=0 immediately.
  - After release, a new frame 7,7,7,7 streams 7,7,7,7,7 correctly.
- Counter wrap: 256 back-to-back frames.
  - frame_cnt reads 255 then 0.
  - Each frame takes 7 cycles with out_ready=1.
